// File: rtl/lsu_ctrl_pkg.sv
// Shared LSU definitions: default data width, funct3 size codes, FSM states, legality rule.
package lsu_ctrl_pkg;

   localparam int CPU_WIDTH = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_e;

   // Stores have no unsigned variants, so any funct3[2] store is illegal.
   function automatic logic access_legal(input logic [2:0] funct3,
                                         input logic       store,
                                         input logic [1:0] addr_lo);
      logic ok;
      case (funct3)
         F3_B, F3_BU: ok = 1'b1;
         F3_H, F3_HU: ok = ~addr_lo[0];
         F3_W:        ok = (addr_lo == 2'b00);
         default:     ok = 1'b0;
      endcase
      return ok & ~(store & funct3[2]);
   endfunction

endpackage

// File: rtl/lsu_ctrl_align.sv
// Byte-lane steering for the LSU: store mask/data shift and load lane extraction/extension.
// Purely combinational, no handshake.
module lsu_align
   import lsu_ctrl_pkg::*;
#(
   parameter int XLEN = CPU_WIDTH
) (
   input  logic [2:0]      funct3_i,
   input  logic [1:0]      addr_lo_i,
   input  logic            we_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [XLEN-1:0] rdata_i,
   output logic [3:0]      wmask_o,
   output logic [XLEN-1:0] wdata_o,
   output logic [XLEN-1:0] ldata_o
);

   logic [4:0]      shamt;
   logic [XLEN-1:0] lane;

   always_comb begin
      shamt   = {addr_lo_i, 3'b000};
      wdata_o = wdata_i << shamt;
      lane    = rdata_i >> shamt;

      wmask_o = 4'b0000;
      if (we_i) begin
         case (funct3_i[1:0])
            2'b00:   wmask_o = 4'b0001 << addr_lo_i;
            2'b01:   wmask_o = 4'b0011 << addr_lo_i;
            default: wmask_o = 4'b1111;
         endcase
      end

      case (funct3_i)
         F3_B:    ldata_o = {{(XLEN-8){lane[7]}}, lane[7:0]};
         F3_H:    ldata_o = {{(XLEN-16){lane[15]}}, lane[15:0]};
         F3_BU:   ldata_o = {{(XLEN-8){1'b0}}, lane[7:0]};
         F3_HU:   ldata_o = {{(XLEN-16){1'b0}}, lane[15:0]};
         default: ldata_o = lane;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one outstanding bus access, illegal/misaligned requests answered locally.
// Latency accept N -> resp N+3 minimum (N+1 for local errors); stalls on gnt, rvalid (bounded by TIMEOUT) and resp_ready.
module lsu_ctrl
   import lsu_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int XLEN    = CPU_WIDTH
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_req_valid,
   output logic            o_req_ready,
   input  logic            i_rden,
   input  logic            i_wren,
   input  logic [XLEN-1:0] i_addr,
   input  logic [XLEN-1:0] i_wdata,
   input  logic [2:0]      i_funct3,
   input  logic [4:0]      i_rd,
   output logic            o_bus_req,
   output logic            o_bus_we,
   output logic [XLEN-1:0] o_bus_addr,
   output logic [XLEN-1:0] o_bus_wdata,
   output logic [3:0]      o_bus_wmask,
   input  logic            i_bus_gnt,
   input  logic            i_bus_rvalid,
   input  logic [XLEN-1:0] i_bus_rdata,
   output logic            o_resp_valid,
   input  logic            i_resp_ready,
   output logic [XLEN-1:0] o_rdata,
   output logic [4:0]      o_rd,
   output logic            o_err
);

   localparam int            CW      = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic              rden_q, rden_d, wren_q, wren_d;
   logic [XLEN-1:0]   addr_q, addr_d, wdata_q, wdata_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [4:0]        rd_q, rd_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic              err_q, err_d;

   logic              req_go;
   logic              timeout_hit;
   logic [3:0]        al_wmask;
   logic [XLEN-1:0]   al_wdata, al_ldata;

   lsu_align #(.XLEN(XLEN)) u_align (
      .funct3_i  (funct3_q),
      .addr_lo_i (addr_q[1:0]),
      .we_i      (wren_q),
      .wdata_i   (wdata_q),
      .rdata_i   (i_bus_rdata),
      .wmask_o   (al_wmask),
      .wdata_o   (al_wdata),
      .ldata_o   (al_ldata)
   );

   assign req_go      = (i_rden | i_wren) & access_legal(i_funct3, i_wren, i_addr[1:0]);
   assign timeout_hit = (cnt_q == TO_LAST);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (i_req_valid) state_d = req_go ? S_REQ : S_RESP;
         S_REQ:  if (i_bus_gnt) state_d = S_WAIT;
         S_WAIT: if (i_bus_rvalid || timeout_hit) state_d = S_RESP;
         S_RESP: if (i_resp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      o_req_ready  = (state_q == S_IDLE);
      o_bus_req    = (state_q == S_REQ);
      o_bus_we     = o_bus_req & wren_q;
      o_bus_addr   = o_bus_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
      o_bus_wdata  = o_bus_req ? al_wdata : '0;
      o_bus_wmask  = o_bus_req ? al_wmask : 4'b0000;
      o_resp_valid = (state_q == S_RESP);
      o_rdata      = rdata_q;
      o_rd         = rd_q;
      o_err        = err_q;
   end

   always_comb begin
      rden_d   = rden_q;
      wren_d   = wren_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      funct3_d = funct3_q;
      rd_d     = rd_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE: if (i_req_valid) begin
            rden_d   = i_rden;
            wren_d   = i_wren;
            addr_d   = i_addr;
            wdata_d  = i_wdata;
            funct3_d = i_funct3;
            rd_d     = i_rd;
            rdata_d  = '0;
            err_d    = (i_rden | i_wren) & ~req_go;
         end
         S_REQ: if (i_bus_gnt) cnt_d = '0;
         S_WAIT: begin
            if (i_bus_rvalid) begin
               rdata_d = wren_q ? '0 : al_ldata;
               err_d   = 1'b0;
            end else if (timeout_hit) begin
               rdata_d = '0;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rden_q   <= 1'b0;
         wren_q   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         funct3_q <= 3'b000;
         rd_q     <= 5'd0;
         cnt_q    <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         rden_q   <= rden_d;
         wren_q   <= wren_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         funct3_q <= funct3_d;
         rd_q     <= rd_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed and randomized bench for lsu_ctrl against a byte-arithmetic reference model.
module tb_lsu_ctrl;

   localparam int TO = 4;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_req_valid, o_req_ready;
   logic        i_rden, i_wren;
   logic [31:0] i_addr, i_wdata;
   logic [2:0]  i_funct3;
   logic [4:0]  i_rd;
   logic        o_bus_req, o_bus_we;
   logic [31:0] o_bus_addr, o_bus_wdata;
   logic [3:0]  o_bus_wmask;
   logic        i_bus_gnt, i_bus_rvalid;
   logic [31:0] i_bus_rdata;
   logic        o_resp_valid, i_resp_ready;
   logic [31:0] o_rdata;
   logic [4:0]  o_rd;
   logic        o_err;

   int vectors     = 0;
   int miscompares = 0;

   lsu_ctrl #(.TIMEOUT(TO), .XLEN(32)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_rden(i_rden), .i_wren(i_wren), .i_addr(i_addr), .i_wdata(i_wdata),
      .i_funct3(i_funct3), .i_rd(i_rd),
      .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
      .o_bus_wdata(o_bus_wdata), .o_bus_wmask(o_bus_wmask),
      .i_bus_gnt(i_bus_gnt), .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata),
      .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
      .o_rdata(o_rdata), .o_rd(o_rd), .o_err(o_err)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      bit        bus;
      bit        err;
      bit [31:0] rdata;
      bit [3:0]  wmask;
      bit [31:0] wdata;
      bit [31:0] baddr;
   } exp_t;

   // Expected outcome from access size in bytes and byte offset.
   function automatic exp_t model(bit rd, bit wr, bit [2:0] f3, bit [31:0] a,
                                  bit [31:0] wd, bit [31:0] rdv);
      exp_t   m;
      int     size;
      bit     sgn;
      int     off;
      longint v;
      m    = '0;
      off  = int'(a % 4);
      sgn  = 1'b0;
      case (f3)
         3'd0:    begin size = 1; sgn = 1'b1; end
         3'd1:    begin size = 2; sgn = 1'b1; end
         3'd2:    size = 4;
         3'd4:    size = 1;
         3'd5:    size = 2;
         default: size = 0;
      endcase
      if (!rd && !wr) return m;
      if (size == 0 || (wr && f3 >= 3'd4) || (off % size) != 0) begin
         m.err = 1'b1;
         return m;
      end
      m.bus   = 1'b1;
      m.baddr = a - 32'(off);
      if (wr) begin
         m.wmask = 4'(((1 << size) - 1) << off);
         m.wdata = wd << (8 * off);
      end else begin
         v = longint'(rdv >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
         if (sgn && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
         m.rdata = v[31:0];
      end
      return m;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      i_req_valid = 0; i_rden = 0; i_wren = 0; i_addr = '0; i_wdata = '0;
      i_funct3 = '0; i_rd = '0; i_bus_gnt = 0; i_bus_rvalid = 0; i_bus_rdata = '0;
      i_resp_ready = 0;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_req_ready"}, 32'(o_req_ready), 32'd1);
      chk({tag, "_bus_req"},   32'(o_bus_req), 32'd0);
      chk({tag, "_bus_we"},    32'(o_bus_we), 32'd0);
      chk({tag, "_bus_addr"},  o_bus_addr, 32'd0);
      chk({tag, "_bus_wdata"}, o_bus_wdata, 32'd0);
      chk({tag, "_bus_wmask"}, 32'(o_bus_wmask), 32'd0);
      chk({tag, "_resp_vld"},  32'(o_resp_valid), 32'd0);
      chk({tag, "_rdata"},     o_rdata, 32'd0);
      chk({tag, "_rd"},        32'(o_rd), 32'd0);
      chk({tag, "_err"},       32'(o_err), 32'd0);
   endtask

   // Runs one access from a negedge in IDLE to the negedge after the response is taken.
   // rv_dly >= TO withholds rvalid so the access times out.
   task automatic do_access(input bit rd, input bit wr, input bit [2:0] f3,
                            input bit [31:0] a, input bit [31:0] wd, input bit [31:0] rdv,
                            input bit [4:0] tag, input int gnt_dly, input int rv_dly,
                            input int rr_dly);
      exp_t e;
      e = model(rd, wr, f3, a, wd, rdv);
      chk("accept_ready", 32'(o_req_ready), 32'd1);
      i_req_valid = 1; i_rden = rd; i_wren = wr; i_funct3 = f3;
      i_addr = a; i_wdata = wd; i_rd = tag;
      @(negedge i_clk);
      i_req_valid = 0; i_rden = 1'($urandom); i_wren = 1'($urandom);
      i_funct3 = 3'($urandom); i_addr = $urandom; i_wdata = $urandom; i_rd = 5'($urandom);
      if (e.bus) begin
         for (int k = 0; k <= gnt_dly; k++) begin
            chk("req_bus_req", 32'(o_bus_req), 32'd1);
            chk("req_bus_addr", o_bus_addr, e.baddr);
            chk("req_bus_we", 32'(o_bus_we), 32'(wr));
            chk("req_bus_wmask", 32'(o_bus_wmask), 32'(e.wmask));
            if (wr) chk("req_bus_wdata", o_bus_wdata, e.wdata);
            chk("req_resp_vld", 32'(o_resp_valid), 32'd0);
            i_bus_gnt = (k == gnt_dly);
            i_bus_rvalid = 1'($urandom);
            i_bus_rdata = $urandom;
            @(negedge i_clk);
         end
         i_bus_gnt = 0; i_bus_rvalid = 0;
         for (int w = 0; w < TO; w++) begin
            chk("wait_bus_req", 32'(o_bus_req), 32'd0);
            chk("wait_resp_vld", 32'(o_resp_valid), 32'd0);
            i_bus_gnt = 1'($urandom);
            i_bus_rvalid = (w == rv_dly);
            i_bus_rdata = (w == rv_dly) ? rdv : $urandom;
            @(negedge i_clk);
            if (w == rv_dly) break;
         end
         i_bus_gnt = 0; i_bus_rvalid = 0;
         if (rv_dly >= TO) begin
            e.err = 1'b1;
            e.rdata = '0;
         end
      end
      for (int r = 0; r <= rr_dly; r++) begin
         chk("resp_vld", 32'(o_resp_valid), 32'd1);
         chk("resp_rdata", o_rdata, e.rdata);
         chk("resp_err", 32'(o_err), 32'(e.err));
         chk("resp_rd", 32'(o_rd), 32'(tag));
         chk("resp_req_ready", 32'(o_req_ready), 32'd0);
         chk("resp_bus_req", 32'(o_bus_req), 32'd0);
         i_resp_ready = (r == rr_dly);
         i_req_valid = 1; i_rden = 1; i_funct3 = 3'd2; i_addr = '0;
         i_bus_rvalid = 1; i_bus_rdata = $urandom;
         @(negedge i_clk);
      end
      i_resp_ready = 0; i_req_valid = 0; i_bus_rvalid = 0;
      chk("done_resp_vld", 32'(o_resp_valid), 32'd0);
      chk("done_req_ready", 32'(o_req_ready), 32'd1);
   endtask

   task automatic reset_mid_wait();
      i_req_valid = 1; i_rden = 1; i_wren = 0; i_funct3 = 3'd2;
      i_addr = 32'h80000010; i_rd = 5'd9;
      @(negedge i_clk);
      i_req_valid = 0;
      chk("rst_req_phase", 32'(o_bus_req), 32'd1);
      i_bus_gnt = 1;
      @(negedge i_clk);
      i_bus_gnt = 0;
      chk("rst_wait_phase", 32'(o_resp_valid), 32'd0);
      #2 i_rst = 1;
      #1 check_reset_state("rst_async");
      @(negedge i_clk);
      i_rst = 0;
      i_bus_rvalid = 1; i_bus_rdata = 32'hDEADBEEF;
      @(negedge i_clk);
      i_bus_rvalid = 0;
      check_reset_state("rst_late_rvalid");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      i_rst = 1;
      repeat (2) @(negedge i_clk);
      check_reset_state("in_reset");
      i_rst = 0;
      @(negedge i_clk);
      check_reset_state("after_reset");

      do_access(1, 0, 3'd0, 32'h80000003, 32'h0, 32'h80ABCDEF, 5'd7, 0, 0, 0);
      do_access(1, 0, 3'd5, 32'h80000002, 32'h0, 32'h12345678, 5'd3, 0, 0, 0);
      do_access(0, 1, 3'd0, 32'h80000001, 32'h000000AB, 32'h0, 5'd4, 2, 1, 0);
      do_access(1, 0, 3'd2, 32'h80000002, 32'h0, 32'h11111111, 5'd5, 0, 0, 0);
      do_access(1, 0, 3'd2, 32'h80000004, 32'h0, 32'h22222222, 5'd6, 0, TO + 3, 1);
      do_access(1, 0, 3'd1, 32'h80000006, 32'h0, 32'h8001F00D, 5'd8, 1, 2, 3);
      do_access(0, 0, 3'd2, 32'h80000008, 32'h5A5A5A5A, 32'h0, 5'd10, 0, 0, 0);
      do_access(0, 1, 3'd4, 32'h80000000, 32'h000000CC, 32'h0, 5'd11, 0, 0, 0);
      do_access(0, 1, 3'd3, 32'h80000000, 32'h000000CC, 32'h0, 5'd12, 0, 0, 0);
      do_access(0, 1, 3'd1, 32'h80000002, 32'h0000BEEF, 32'h0, 5'd13, 0, TO - 1, 0);
      reset_mid_wait();

      for (int n = 0; n < 200; n++) begin
         do_access(1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
                   32'h80000000 | ($urandom & 32'h0000FFFF), $urandom, $urandom,
                   5'($urandom), $urandom_range(0, 2), $urandom_range(0, 5),
                   $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 255, max cycles in WAIT before abort.
REQ-002 Parameter: XLEN, default `CPU_WIDTH (32), data/address width.
REQ-003 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 i_rst  in  1  reset, asynchronous, active-high.
REQ-005 i_req_valid  in  1  EXU request valid.
REQ-006 o_req_ready  out  1  LSU can accept a request.
REQ-007 i_rden / i_wren  in  1 each  load / store select.
REQ-008 i_addr  in  XLEN  effective address (exu_aluout).
REQ-009 i_wdata  in  XLEN  store data, lane 0 justified.
REQ-010 i_funct3  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 i_rd  in  5  destination register tag.
REQ-012 o_bus_req  out  1  bus request; o_bus_we out 1; o_bus_addr out XLEN, word-aligned; o_bus_wdata out XLEN; o_bus_wmask out 4.
REQ-013 i_bus_gnt  in  1  request accepted; i_bus_rvalid in 1 data/ack; i_bus_rdata in XLEN.
REQ-014 o_resp_valid  out  1  result to WBU; i_resp_ready in 1.
REQ-015 o_rdata  out  XLEN  extended load result; o_rd out 5; o_err out 1 misaligned/illegal/timeout.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, RESP; o_req_ready = (state==IDLE).
REQ-017 IDLE: on i_req_valid, latch all request fields; next state is REQ if access is legal and (rden|wren), else RESP.
REQ-018 Neither rden nor wren: RESP with o_rdata=0, o_err=0, no bus activity.
REQ-019 Illegal funct3 (011,110,111, or any store with funct3[2]=1) or misalignment (H with addr[0]=1; W with addr[1:0]!=0): RESP with o_err=1, o_rdata=0, no bus activity.
REQ-020 REQ: o_bus_req=1 and address/we/wdata/wmask held stable until i_bus_gnt; on gnt go to WAIT.
REQ-021 o_bus_addr = {addr[XLEN-1:2],2'b00}; o_bus_we = latched wren.
REQ-022 o_bus_wmask: B 4'b0001<<addr[1:0]; H 4'b0011<<addr[1:0]; W 4'b1111; 0 on loads.
REQ-023 o_bus_wdata = wdata << (8*addr[1:0]).
REQ-024 WAIT: on i_bus_rvalid capture result, go to RESP; for stores rvalid is the write ack and o_rdata=0.
REQ-025 Load result: lane = rdata >> (8*addr[1:0]); B/H sign-extend lane bit 7/15; BU/HU zero-extend; W unchanged.
REQ-026 WAIT cycle counter clears on WAIT entry; when it reaches TIMEOUT without rvalid: RESP with o_err=1, o_rdata=0.
REQ-027 i_bus_rvalid outside WAIT and i_bus_gnt outside REQ ignored.
REQ-028 RESP: o_resp_valid=1, o_rdata/o_rd/o_err held stable until i_resp_ready; then IDLE.
REQ-029 Minimum latency: accept cycle N, gnt at N+1, rvalid at N+2, o_resp_valid at N+3.
REQ-030 No new request accepted in the cycle a response is consumed (one outstanding access).

Reset
REQ-031 i_rst asserted at any time forces IDLE immediately; o_bus_req, o_resp_valid, o_err=0; o_rdata, o_bus_* = 0; o_rd=0; counter=0.
REQ-032 Reset mid-access abandons transaction; late rvalid after reset is ignored.

Structure
REQ-033 XLEN default, funct3 size codes, and FSM state encodings live in defines.v.
REQ-034 One combinational sub-module lsu_align: wmask/wdata shift and load extraction/extension.

Verification
REQ-035 LB addr 0x80000003, rdata 0x80ABCDEF, gnt/rvalid immediate -> o_rdata 0xFFFFFF80, o_resp_valid at cycle N+3.
REQ-036 LHU addr 0x80000002, rdata 0x12345678 -> o_rdata 0x00001234, o_err 0.
REQ-037 SB wdata 0x000000AB addr 0x80000001 -> o_bus_wmask 4'b0010, o_bus_wdata 0x0000AB00, o_bus_addr 0x80000000.
REQ-038 LW addr 0x80000002 -> o_err 1, o_bus_req never asserted, response in cycle N+1.
REQ-039 LW with rvalid withheld, TIMEOUT=4 -> o_err 1 after 4 WAIT cycles; late rvalid ignored.
REQ-040 i_resp_ready low 3 cycles then high, and i_rst pulsed during WAIT -> outputs stable while stalled; after reset all outputs 0 and o_req_ready 1.
